utils_clock_divider_multi: RTL and testbench
============================================

# utils_clock_divider_multi

Synthesizable, parametrised multi-channel clock divider that generates divided clock waveforms from a single reference `clock`. Each channel has a programmable integer divisor, a programmable high-phase length (duty) and an enable. Each channel also has a one-cycle tick strobe for use as a clock enable. Divisor and duty changes apply only at period boundaries, so outputs never glitch. The block sits in `utils` next to the behavioural simulation divider and replaces it wherever the generated clocks must go through synthesis.

## Interface
Parameters:
- `NCH`, 2, number of independent divider channels (≥1).
- `W`, 8, width of each channel's divisor and high-phase fields.

Ports (channel `c` occupies bits `[c*W +: W]` of the packed buses):
- `clock`  input  1  reference clock; all state changes on posedge.
- `reset`  input  1  asynchronous, active-low reset; one clock; reset is asynchronous and active-low.
- `io_div`  input  NCH*W  divisor per channel; period = div cycles of `clock`; 0 = channel disabled.
- `io_high`  input  NCH*W  high-phase length per channel in `clock` cycles; clamped as below.
- `io_en`  input  NCH  channel enable.
- `io_sync`  input  1  phase-align strobe for all channels.
- `io_clock_out`  output  NCH  divided clock per channel, registered.
- `io_tick`  output  NCH  one-cycle strobe in the first cycle of each output period, registered.
- `io_active`  output  NCH  channel is in RUN state.

## Operation
- Per-channel state:
  - `state` ∈ {IDLE, RUN};
  - counter `cnt` (W bits);
  - shadow registers `div_q` and `high_q` (W bits each).
- Reset (`reset`=0, async): all channels go to IDLE; `cnt`, `div_q` and `high_q` = 0; `io_clock_out`, `io_tick` and `io_active` = 0.
- High clamp, applied when loading: `high_q` = max(1, min(`io_high`, max(`div`-1, 1))).
- A "load" samples `io_div`/`io_high` into `div_q`/`high_q` and sets `cnt`←0, `out`←1, `tick`←1, `state`←RUN.
  - If the sampled `io_div`=0, the load instead gives `state`←IDLE, `out`←0, `tick`←0.
- IDLE:
  - `out`=0, `tick`=0, `cnt`=0.
  - On an edge with `io_en`=1, perform a load.
- RUN, when `cnt` ≠ `div_q`-1:
  - `cnt`←`cnt`+1;
  - `out`←(`cnt`+1 < `high_q`);
  - `tick`←0.
- RUN, when `cnt` = `div_q`-1 (period end):
  - if `io_en`=1, perform a load (this picks up new div/high);
  - otherwise go to IDLE with `out`←0 and `tick`←0.
- Deasserting `io_en` mid-period does not truncate the period. The channel drains to the period end, then goes IDLE.
- `io_sync`=1 at an edge has priority over everything else:
  - every channel with `io_en`=1 performs a load immediately, wherever its `cnt` is;
  - every channel with `io_en`=0 goes to IDLE.
- `div`=1: the channel stays in RUN with `out`=1 constantly and `tick`=1 every cycle.
- `io_active` = (state==RUN).

## Timing
- Outputs are registered. There is no combinational path from inputs to outputs.
- Enable latency: `io_en` sampled high at edge k in IDLE gives `io_clock_out`=1 and `io_tick`=1 in the cycle after edge k.
- In steady state the output is high for `high_q` cycles and low for `div_q`-`high_q` cycles. `io_tick` pulses exactly once per `div_q` cycles, coincident with the rising output.
- Changes to `io_div`/`io_high` mid-period are ignored until the period-end edge. Values are sampled only at that edge.
- Simultaneous events:
  - `io_sync` together with a period end: treat as a single load.
  - `io_sync` while IDLE with `io_en`=1: behaves exactly as an enable.
- Reset mid-period: outputs drop to 0 asynchronously. After release, a channel restarts only through the normal IDLE→load path.
- `W`-bit arithmetic: `cnt`+1 never overflows, because `cnt` ≤ `div_q`-1 ≤ 2^W-2.

## Test plan
- Channel 0 with div=4, high=2, en=1 from reset release: `io_clock_out` = 1,1,0,0 repeating; `io_tick` = 1,0,0,0; first high appears one cycle after en is sampled.
- Duty clamps:
  - div=3, high=0: out = 1,0,0.
  - div=3, high=9: out = 1,1,0.
  - div=1, any high: out constantly 1, tick every cycle.
- Divisor change mid-period (div 4→6, high 2→3, applied in cycle 1 of a period): remainder of the current period keeps pattern 1,1,0,0; the next period is 1,1,1,0,0,0 with no extra edges.
- Enable drop at `cnt`=1 with div=5: the period completes (5 cycles total), then `io_active`=0 and out=0. Re-asserting en gives a tick one cycle later.
- Two channels: div=4 and div=6, offset by staggered enables. Pulse `io_sync` once: both channels show tick=1 and out=1 in the next cycle and stay phase-aligned, ticking together every 12 cycles.
- Async reset asserted mid-run between clock edges: all outputs go to 0 immediately. div=0 with en=1 after release: the channel stays IDLE, `io_active`=0.

Source files
------------

// File: rtl/utils_clock_divider_multi.sv
// Multi-channel glitch-free integer clock divider with per-channel duty and tick strobe.
// Outputs are registered: one clock from a sampled enable/sync to the first high/tick.
module utils_clock_divider_multi #(
  parameter int NCH = 2,
  parameter int W   = 8
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [NCH*W-1:0] io_div,
  input  logic [NCH*W-1:0] io_high,
  input  logic [NCH-1:0]   io_en,
  input  logic             io_sync,
  output logic [NCH-1:0]   io_clock_out,
  output logic [NCH-1:0]   io_tick,
  output logic [NCH-1:0]   io_active
);

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_e;

  for (genvar c = 0; c < NCH; c++) begin : g_ch
    state_e       state_q, state_d;
    logic [W-1:0] cnt_q, cnt_d;
    logic [W-1:0] div_q, div_d;
    logic [W-1:0] high_q, high_d;
    logic         out_q, out_d;
    logic         tick_q, tick_d;

    logic [W-1:0] div_in;
    logic [W-1:0] high_in;
    logic [W-1:0] high_lim;
    logic [W-1:0] high_clamp;
    logic         period_end;
    logic         load;

    assign div_in  = io_div[c*W +: W];
    assign high_in = io_high[c*W +: W];

    // High phase must leave at least one low cycle, except div<=2 where it is pinned to 1.
    assign high_lim   = (div_in > W'(2)) ? (div_in - W'(1)) : W'(1);
    assign high_clamp = (high_in == '0) ? W'(1) :
                        ((high_in < high_lim) ? high_in : high_lim);
    assign period_end = (cnt_q == (div_q - W'(1)));

    always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      div_d   = div_q;
      high_d  = high_q;
      out_d   = out_q;
      tick_d  = 1'b0;
      load    = 1'b0;

      if (io_sync) begin
        if (io_en[c]) begin
          load = 1'b1;
        end else begin
          state_d = IDLE;
          cnt_d   = '0;
          out_d   = 1'b0;
        end
      end else begin
        case (state_q)
          IDLE: begin
            cnt_d = '0;
            out_d = 1'b0;
            if (io_en[c]) load = 1'b1;
          end
          RUN: begin
            if (!period_end) begin
              cnt_d = cnt_q + W'(1);
              out_d = ((cnt_q + W'(1)) < high_q);
            end else if (io_en[c]) begin
              load = 1'b1;
            end else begin
              state_d = IDLE;
              cnt_d   = '0;
              out_d   = 1'b0;
            end
          end
          default: begin
            state_d = IDLE;
            cnt_d   = '0;
            out_d   = 1'b0;
          end
        endcase
      end

      // New div/high only ever enter the shadows here, so the waveform never glitches.
      if (load) begin
        div_d  = div_in;
        high_d = high_clamp;
        cnt_d  = '0;
        if (div_in == '0) begin
          state_d = IDLE;
          out_d   = 1'b0;
          tick_d  = 1'b0;
        end else begin
          state_d = RUN;
          out_d   = 1'b1;
          tick_d  = 1'b1;
        end
      end
    end

    always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
        state_q <= IDLE;
        cnt_q   <= '0;
        div_q   <= '0;
        high_q  <= '0;
        out_q   <= 1'b0;
        tick_q  <= 1'b0;
      end else begin
        state_q <= state_d;
        cnt_q   <= cnt_d;
        div_q   <= div_d;
        high_q  <= high_d;
        out_q   <= out_d;
        tick_q  <= tick_d;
      end
    end

    assign io_clock_out[c] = out_q;
    assign io_tick[c]      = tick_q;
    assign io_active[c]    = (state_q == RUN);
  end

endmodule

// File: tb/tb_utils_clock_divider_multi.sv
// Randomised and directed stimulus against a period/position reference model, scoreboard checked.
module tb_utils_clock_divider_multi;
  localparam int NCH = 2;
  localparam int W   = 8;

  logic             clock = 1'b0;
  logic             reset;
  logic [NCH*W-1:0] io_div;
  logic [NCH*W-1:0] io_high;
  logic [NCH-1:0]   io_en;
  logic             io_sync;
  logic [NCH-1:0]   io_clock_out;
  logic [NCH-1:0]   io_tick;
  logic [NCH-1:0]   io_active;

  utils_clock_divider_multi #(.NCH(NCH), .W(W)) dut (
    .clock        (clock),
    .reset        (reset),
    .io_div       (io_div),
    .io_high      (io_high),
    .io_en        (io_en),
    .io_sync      (io_sync),
    .io_clock_out (io_clock_out),
    .io_tick      (io_tick),
    .io_active    (io_active)
  );

  always #5 clock = ~clock;

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic [NCH-1:0] clk;
    logic [NCH-1:0] tick;
    logic [NCH-1:0] act;
  } exp_t;

  exp_t sb_q[$];

  // Reference: each channel is either stopped or at position pos within a period of (div, high).
  bit m_run [NCH] = '{default: 1'b0};
  int m_div [NCH] = '{default: 0};
  int m_high[NCH] = '{default: 0};
  int m_pos [NCH] = '{default: 0};

  function automatic void m_start(int c);
    int d;
    int h;
    int lim;
    d = int'(io_div[c*W +: W]);
    h = int'(io_high[c*W +: W]);
    if (d == 0) begin
      m_run[c] = 1'b0;
    end else begin
      lim = (d - 1 > 1) ? d - 1 : 1;
      if (h > lim) h = lim;
      if (h < 1) h = 1;
      m_run[c]  = 1'b1;
      m_div[c]  = d;
      m_high[c] = h;
      m_pos[c]  = 0;
    end
  endfunction

  always @(negedge reset) begin
    for (int c = 0; c < NCH; c++) m_run[c] = 1'b0;
  end

  always @(posedge clock) begin
    exp_t e;
    if (reset === 1'b1) begin
      for (int c = 0; c < NCH; c++) begin
        if (io_sync || !m_run[c] || m_pos[c] == m_div[c] - 1) begin
          if (io_en[c]) m_start(c);
          else m_run[c] = 1'b0;
        end else begin
          m_pos[c] = m_pos[c] + 1;
        end
        e.clk[c]  = m_run[c] && (m_pos[c] < m_high[c]);
        e.tick[c] = m_run[c] && (m_pos[c] == 0);
        e.act[c]  = m_run[c];
      end
      sb_q.push_back(e);
    end
  end

  always @(posedge clock) begin
    exp_t e;
    #1;
    if (sb_q.size() != 0) begin
      e = sb_q.pop_front();
      checks++;
      if ({io_clock_out, io_tick, io_active} !== e) begin
        errors++;
        $display("FAIL cycle_cmp t=%0t got clk=%b tick=%b act=%b expected clk=%b tick=%b act=%b",
                 $time, io_clock_out, io_tick, io_active, e.clk, e.tick, e.act);
      end
    end
  end

  task automatic chk(input string name, input logic [3*NCH-1:0] got, input logic [3*NCH-1:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s t=%0t got=%b expected=%b", name, $time, got, exp);
    end
  endtask

  task automatic set_ch(input int c, input int d, input int h, input bit e);
    io_div[c*W +: W]  = W'(d);
    io_high[c*W +: W] = W'(h);
    io_en[c]          = e;
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clock);
  endtask

  initial begin
    reset   = 1'b0;
    io_div  = '0;
    io_high = '0;
    io_en   = '0;
    io_sync = 1'b0;
    cyc(3);
    chk("reset_state", {io_clock_out, io_tick, io_active}, '0);

    // Basic 4/2 from reset release
    set_ch(0, 4, 2, 1'b1);
    reset = 1'b1;
    cyc(12);

    // Duty clamps
    set_ch(0, 3, 0, 1'b1);
    cyc(9);
    set_ch(0, 3, 9, 1'b1);
    cyc(9);
    set_ch(0, 1, 7, 1'b1);
    cyc(6);

    // Mid-period divisor change
    set_ch(0, 4, 2, 1'b1);
    cyc(9);
    set_ch(0, 6, 3, 1'b1);
    cyc(14);

    // Enable drop early in a div=5 period, then re-enable
    set_ch(0, 5, 2, 1'b1);
    io_sync = 1'b1;
    cyc(1);
    io_sync = 1'b0;
    cyc(1);
    io_en[0] = 1'b0;
    cyc(8);
    io_en[0] = 1'b1;
    cyc(7);

    // Two staggered channels then a sync pulse
    set_ch(0, 4, 2, 1'b1);
    cyc(3);
    set_ch(1, 6, 3, 1'b1);
    cyc(7);
    io_sync = 1'b1;
    cyc(1);
    io_sync = 1'b0;
    cyc(30);

    // Async reset between edges, then div=0 with enable
    @(posedge clock);
    #3;
    reset = 1'b0;
    #1;
    chk("async_reset", {io_clock_out, io_tick, io_active}, '0);
    cyc(2);
    set_ch(0, 0, 3, 1'b1);
    set_ch(1, 0, 0, 1'b0);
    reset = 1'b1;
    cyc(6);

    // Randomised traffic
    for (int i = 0; i < 1500; i++) begin
      for (int c = 0; c < NCH; c++) begin
        if ($urandom_range(0, 7) == 0) begin
          io_div[c*W +: W]  = W'($urandom_range(0, 3) == 0 ? $urandom_range(0, 14) : $urandom_range(1, 6));
          io_high[c*W +: W] = W'($urandom_range(0, 10));
        end
        if ($urandom_range(0, 15) == 0) io_en[c] = ~io_en[c];
      end
      io_sync = ($urandom_range(0, 39) == 0);
      cyc(1);
    end

    io_sync = 1'b0;
    io_en   = '0;
    cyc(30);
    checks++;
    if (sb_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain left=%0d expected=0", sb_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
